pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register for the MIPS datapath. It generalises the fixed ID/EX-style latch to an arbitrary payload width and adds a valid bit and a separate flush input. The Tnew hazard field saturating-decrements as it passes through the stage. Three selectable stall modes are provided: legacy bubble-on-stall, hold-on-stall, and elastic valid/ready with a skid buffer. The block is instantiated between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and feeds the hazard unit a per-stage bubble counter.

Parameters:
DW, 32, payload width in bits (packed control and data fields).
TW, 2, width of the Tnew field.
CW, 8, width of the bubble counter.
MODE, 0, stall mode: 0 = BUBBLE, 1 = HOLD, 2 = ELASTIC.

Ports:
clk  input  1  clock, all state updates on its rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  upstream entry is a real instruction
in_ready  output  1  stage accepts the input this cycle
in_data  input  DW  upstream payload
in_tnew  input  TW  upstream Tnew
stall  input  1  hazard-unit stall; ignored in MODE 2
flush  input  1  kill the stage contents; used for branch or exception
out_valid  output  1  stage holds a real instruction
out_ready  input  1  downstream consumes; used only in MODE 2
out_data  output  DW  registered payload
out_tnew  output  TW  registered Tnew
bubble_cnt  output  CW  saturating count of bubble cycles

Behaviour:
- Reset values (synchronous, priority over everything):
  - out_valid=0, out_data=0, out_tnew=0, bubble_cnt=0.
  - Skid buffer empty; in_ready=1 from the first edge after rst deasserts (MODE 2).
- sat_dec(t): t==0 → 0, otherwise t-1. It is applied to in_tnew whenever an entry is captured from the input.
- MODE 0 (BUBBLE), one-cycle latency, in_ready = ~stall (combinational):
  - If flush or stall: out_valid, out_data and out_tnew are all loaded with 0.
  - Otherwise: out_data<=in_data, out_valid<=in_valid, out_tnew<=sat_dec(in_tnew).
  - out_ready is ignored.
- MODE 1 (HOLD), in_ready = ~stall:
  - Priority is flush > stall > load.
  - flush: load zeros, as in MODE 0.
  - stall: all outputs keep their value.
  - Otherwise: load as in MODE 0.
  - out_ready is ignored.
- MODE 2 (ELASTIC):
  - State: one output register plus one skid register (data, tnew, full flag).
  - in_ready is registered and equals "skid empty".
  - Accept happens when in_valid & in_ready; consume happens when out_valid & out_ready.
  - Per edge, when the output register is empty or being consumed:
    - Load it from the skid register if the skid is full, otherwise from the accepted input.
    - If neither source is available, out_valid<=0.
  - Per edge, when the output register is full, not consumed, and an input is accepted:
    - The input goes to the skid register; in_ready<=0 next cycle.
  - Skid full and output consumed: skid moves to the output, and in_ready<=1 next cycle. This holds only if no input is also accepted. Accepting an input is impossible while the skid is full, because in_ready=0.
  - flush: clears out_valid and the skid full flag, sets in_ready<=1, and discards any same-cycle accept. out_data and out_tnew are zeroed.
  - Throughput is one entry per cycle with no combinational path from out_ready to in_ready.
  - Data is never duplicated or dropped except by flush.
- Simultaneous flush and stall (MODE 0/1): flush wins and the result is a bubble.
- Simultaneous flush and rst: rst wins, so bubble_cnt is cleared, not incremented.
- bubble_cnt:
  - On each non-reset edge where the next out_valid is 0, bubble_cnt<=bubble_cnt+1.
  - It saturates at 2^CW-1.
  - It does not count HOLD cycles that retain out_valid=1.
- Widths: out_data and out_tnew match the input widths exactly; there is no truncation or sign extension.

Test Plan:
- MODE 0, DW=32, TW=2: in_valid=1, in_data=0x8C220004, in_tnew=2, stall=0 → next cycle out_valid=1, out_data=0x8C220004, out_tnew=1. With in_tnew=0 → out_tnew=0.
- MODE 0, stall=1 for 2 cycles while in_data=0x12345678 → out_valid=0, out_data=0, out_tnew=0, in_ready=0 for both cycles. bubble_cnt increments by 2.
- MODE 1: load 0xDEADBEEF, then stall=1 for 3 cycles → out_data stays 0xDEADBEEF, out_valid=1, bubble_cnt unchanged. Then assert stall=1 and flush=1 together → out_valid=0, out_data=0.
- MODE 2: stream entries 1..6 with out_ready toggling 1,0,0,1,1,1 → out_data sequence 1..6 appears in order with none lost or duplicated. in_ready drops to 0 exactly one cycle after the skid register fills.
- MODE 2: skid full with entry A in the output and entry B in the skid, then flush=1 with in_valid=1 (entry C) → next cycle out_valid=0, in_ready=1. C is not captured.
- CW=2, MODE 0, stall held 5 cycles → bubble_cnt sequence 1,2,3,3,3. Then rst=1 for one edge → bubble_cnt=0, out_valid=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register for the MIPS datapath.
// Carries a payload, a valid bit and a Tnew hazard field that is
// saturating-decremented on capture. Three stall behaviours are
// selected by MODE: 0 = bubble-on-stall, 1 = hold-on-stall,
// 2 = elastic valid/ready with a one-entry skid buffer.
// A saturating counter reports how many edges left the stage empty.
module pipe_stage_reg #(
  parameter int DW   = 32,
  parameter int TW   = 2,
  parameter int CW   = 8,
  parameter int MODE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [TW-1:0] in_tnew,
  input  logic          stall,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [TW-1:0] out_tnew,
  output logic [CW-1:0] bubble_cnt
);

  localparam bit IS_HOLD    = (MODE == 1);
  localparam bit IS_ELASTIC = (MODE == 2);

  // Tnew counts down one per stage but never wraps below zero.
  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // Architectural state
  logic          r_out_valid;
  logic [DW-1:0] r_out_data;
  logic [TW-1:0] r_out_tnew;
  logic          r_skid_full;
  logic [DW-1:0] r_skid_data;
  logic [TW-1:0] r_skid_tnew;
  logic          r_in_ready;
  logic [CW-1:0] r_bubble_cnt;

  // Next-state values
  logic          w_nxt_out_valid;
  logic [DW-1:0] w_nxt_out_data;
  logic [TW-1:0] w_nxt_out_tnew;
  logic          w_nxt_skid_full;
  logic [DW-1:0] w_nxt_skid_data;
  logic [TW-1:0] w_nxt_skid_tnew;
  logic          w_nxt_in_ready;
  logic [CW-1:0] w_nxt_bubble_cnt;

  logic          w_accept;
  logic          w_consume;
  logic [TW-1:0] w_in_tnew_dec;

  assign w_accept      = in_valid & r_in_ready;
  assign w_consume     = r_out_valid & out_ready;
  assign w_in_tnew_dec = sat_dec(in_tnew);

  // Elastic mode uses the registered skid-empty flag so out_ready never
  // reaches in_ready combinationally; the other modes follow the stall.
  assign in_ready = IS_ELASTIC ? r_in_ready : ~stall;

  // Next-state selection for the output register, skid buffer and counter.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    w_nxt_out_valid = r_out_valid;
    w_nxt_out_data  = r_out_data;
    w_nxt_out_tnew  = r_out_tnew;
    w_nxt_skid_full = r_skid_full;
    w_nxt_skid_data = r_skid_data;
    w_nxt_skid_tnew = r_skid_tnew;
    w_nxt_in_ready  = r_in_ready;

    if (IS_ELASTIC) begin
      if (flush) begin
        // Kill both slots; a same-cycle accept is discarded.
        w_nxt_out_valid = 1'b0;
        w_nxt_out_data  = '0;
        w_nxt_out_tnew  = '0;
        w_nxt_skid_full = 1'b0;
      end else if (!r_out_valid || w_consume) begin
        // Output slot is free this edge: the skid entry is older, so it
        // goes first; otherwise take the accepted input directly.
        if (r_skid_full) begin
          w_nxt_out_valid = 1'b1;
          w_nxt_out_data  = r_skid_data;
          w_nxt_out_tnew  = r_skid_tnew;
          w_nxt_skid_full = 1'b0;
        end else if (w_accept) begin
          w_nxt_out_valid = 1'b1;
          w_nxt_out_data  = in_data;
          w_nxt_out_tnew  = w_in_tnew_dec;
        end else begin
          w_nxt_out_valid = 1'b0;
        end
      end else if (w_accept) begin
        // Output is stuck downstream: park the new entry in the skid.
        w_nxt_skid_full = 1'b1;
        w_nxt_skid_data = in_data;
        w_nxt_skid_tnew = w_in_tnew_dec;
      end
      w_nxt_in_ready = !w_nxt_skid_full;
    end else begin
      if (flush || (stall && !IS_HOLD)) begin
        // Insert a bubble: the whole payload is zeroed, not just valid.
        w_nxt_out_valid = 1'b0;
        w_nxt_out_data  = '0;
        w_nxt_out_tnew  = '0;
      end else if (!stall) begin
        w_nxt_out_valid = in_valid;
        w_nxt_out_data  = in_data;
        w_nxt_out_tnew  = w_in_tnew_dec;
      end
      // Remaining case is a HOLD stall: defaults keep everything.
    end

    // Count edges that leave the stage empty, sticking at all-ones.
    w_nxt_bubble_cnt = r_bubble_cnt;
    if (!w_nxt_out_valid && (r_bubble_cnt != '1)) begin
      w_nxt_bubble_cnt = r_bubble_cnt + CW'(1);
    end
  end

  // State register with synchronous, active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so
    // every register samples the pre-edge values computed above.
    if (rst) begin
      // NOTE: the payload registers are reset too, because downstream
      // stages and the hazard unit observe out_data/out_tnew directly.
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_tnew   <= '0;
      r_skid_full  <= 1'b0;
      r_skid_data  <= '0;
      r_skid_tnew  <= '0;
      r_in_ready   <= 1'b0;
      r_bubble_cnt <= '0;
    end else begin
      r_out_valid  <= w_nxt_out_valid;
      r_out_data   <= w_nxt_out_data;
      r_out_tnew   <= w_nxt_out_tnew;
      r_skid_full  <= w_nxt_skid_full;
      r_skid_data  <= w_nxt_skid_data;
      r_skid_tnew  <= w_nxt_skid_tnew;
      r_in_ready   <= w_nxt_in_ready;
      r_bubble_cnt <= w_nxt_bubble_cnt;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_tnew   = r_out_tnew;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: one instance per stall mode plus a
// narrow-counter instance. MODE 0/1 are driven from a shared vector table;
// MODE 2 streaming is checked through an expected-data queue.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;
  logic        rst_c2;
  logic        in_valid;
  logic [31:0] in_data;
  logic [1:0]  in_tnew;
  logic        stall;
  logic        stall_c2;
  logic        flush;
  logic        out_ready;

  logic        m0_in_ready, m0_out_valid;
  logic [31:0] m0_out_data;
  logic [1:0]  m0_out_tnew;
  logic [7:0]  m0_bcnt;

  logic        m1_in_ready, m1_out_valid;
  logic [31:0] m1_out_data;
  logic [1:0]  m1_out_tnew;
  logic [7:0]  m1_bcnt;

  logic        m2_in_ready, m2_out_valid;
  logic [31:0] m2_out_data;
  logic [1:0]  m2_out_tnew;
  logic [7:0]  m2_bcnt;

  logic        c2_in_ready, c2_out_valid;
  logic [31:0] c2_out_data;
  logic [1:0]  c2_out_tnew;
  logic [1:0]  c2_bcnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_reg #(.DW(32), .TW(2), .CW(8), .MODE(0)) u_m0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m0_in_ready),
    .in_data(in_data), .in_tnew(in_tnew), .stall(stall), .flush(flush),
    .out_valid(m0_out_valid), .out_ready(out_ready), .out_data(m0_out_data),
    .out_tnew(m0_out_tnew), .bubble_cnt(m0_bcnt)
  );

  pipe_stage_reg #(.DW(32), .TW(2), .CW(8), .MODE(1)) u_m1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m1_in_ready),
    .in_data(in_data), .in_tnew(in_tnew), .stall(stall), .flush(flush),
    .out_valid(m1_out_valid), .out_ready(out_ready), .out_data(m1_out_data),
    .out_tnew(m1_out_tnew), .bubble_cnt(m1_bcnt)
  );

  pipe_stage_reg #(.DW(32), .TW(2), .CW(8), .MODE(2)) u_m2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m2_in_ready),
    .in_data(in_data), .in_tnew(in_tnew), .stall(stall), .flush(flush),
    .out_valid(m2_out_valid), .out_ready(out_ready), .out_data(m2_out_data),
    .out_tnew(m2_out_tnew), .bubble_cnt(m2_bcnt)
  );

  pipe_stage_reg #(.DW(32), .TW(2), .CW(2), .MODE(0)) u_c2 (
    .clk(clk), .rst(rst_c2), .in_valid(in_valid), .in_ready(c2_in_ready),
    .in_data(in_data), .in_tnew(in_tnew), .stall(stall_c2), .flush(flush),
    .out_valid(c2_out_valid), .out_ready(out_ready), .out_data(c2_out_data),
    .out_tnew(c2_out_tnew), .bubble_cnt(c2_bcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic [1:0]  t;
    logic        s;
    logic        f;
    logic        v0;
    logic [31:0] d0;
    logic [1:0]  t0;
    logic        v1;
    logic [31:0] d1;
    logic [1:0]  t1;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          m0_bc;
    int          m1_bc;
    int          idx;
    int          cyc;
    int          popped;
    logic [31:0] q[$];
    logic [31:0] exp_d;
    bit          or_pat[6];
    bit          rdy_pat[6];

    vecs[0]  = '{1'b1, 32'h8C220004, 2'd2, 1'b0, 1'b0, 1'b1, 32'h8C220004, 2'd1, 1'b1, 32'h8C220004, 2'd1};
    vecs[1]  = '{1'b1, 32'h00001111, 2'd0, 1'b0, 1'b0, 1'b1, 32'h00001111, 2'd0, 1'b1, 32'h00001111, 2'd0};
    vecs[2]  = '{1'b1, 32'h12345678, 2'd3, 1'b1, 1'b0, 1'b0, 32'h0,        2'd0, 1'b1, 32'h00001111, 2'd0};
    vecs[3]  = '{1'b1, 32'h12345678, 2'd3, 1'b1, 1'b0, 1'b0, 32'h0,        2'd0, 1'b1, 32'h00001111, 2'd0};
    vecs[4]  = '{1'b1, 32'hDEADBEEF, 2'd1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 2'd0, 1'b1, 32'hDEADBEEF, 2'd0};
    vecs[5]  = '{1'b1, 32'hA5A5A5A5, 2'd3, 1'b1, 1'b0, 1'b0, 32'h0,        2'd0, 1'b1, 32'hDEADBEEF, 2'd0};
    vecs[6]  = '{1'b1, 32'hA5A5A5A5, 2'd3, 1'b1, 1'b0, 1'b0, 32'h0,        2'd0, 1'b1, 32'hDEADBEEF, 2'd0};
    vecs[7]  = '{1'b1, 32'hA5A5A5A5, 2'd3, 1'b1, 1'b0, 1'b0, 32'h0,        2'd0, 1'b1, 32'hDEADBEEF, 2'd0};
    vecs[8]  = '{1'b1, 32'hA5A5A5A5, 2'd3, 1'b1, 1'b1, 1'b0, 32'h0,        2'd0, 1'b0, 32'h0,        2'd0};
    vecs[9]  = '{1'b0, 32'hCAFEF00D, 2'd2, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D, 2'd1, 1'b0, 32'hCAFEF00D, 2'd1};
    vecs[10] = '{1'b1, 32'hFFFFFFFF, 2'd3, 1'b0, 1'b1, 1'b0, 32'h0,        2'd0, 1'b0, 32'h0,        2'd0};
    vecs[11] = '{1'b1, 32'hFFFFFFFF, 2'd3, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 2'd2, 1'b1, 32'hFFFFFFFF, 2'd2};

    or_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset phase
    rst = 1'b1; rst_c2 = 1'b1;
    in_valid = 1'b0; in_data = '0; in_tnew = '0;
    stall = 1'b0; stall_c2 = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #1;
    tick(); tick();
    check("rst_m0_valid", m0_out_valid, 0);
    check("rst_m0_data",  m0_out_data,  0);
    check("rst_m0_tnew",  m0_out_tnew,  0);
    check("rst_m0_bcnt",  m0_bcnt,      0);
    check("rst_m1_valid", m1_out_valid, 0);
    check("rst_m2_valid", m2_out_valid, 0);
    check("rst_m2_ready", m2_in_ready,  0);
    check("rst_c2_bcnt",  c2_bcnt,      0);
    rst = 1'b0;

    // MODE 0 / MODE 1 vector table
    m0_bc = 0;
    m1_bc = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid = vecs[i].iv;
      in_data  = vecs[i].d;
      in_tnew  = vecs[i].t;
      stall    = vecs[i].s;
      flush    = vecs[i].f;
      #1;
      check($sformatf("v%0d_m0_in_ready", i), m0_in_ready, !vecs[i].s);
      check($sformatf("v%0d_m1_in_ready", i), m1_in_ready, !vecs[i].s);
      tick();
      if (!vecs[i].v0) m0_bc++;
      if (!vecs[i].v1) m1_bc++;
      check($sformatf("v%0d_m0_valid", i), m0_out_valid, vecs[i].v0);
      check($sformatf("v%0d_m0_data", i),  m0_out_data,  vecs[i].d0);
      check($sformatf("v%0d_m0_tnew", i),  m0_out_tnew,  vecs[i].t0);
      check($sformatf("v%0d_m0_bcnt", i),  m0_bcnt,      m0_bc);
      check($sformatf("v%0d_m1_valid", i), m1_out_valid, vecs[i].v1);
      check($sformatf("v%0d_m1_data", i),  m1_out_data,  vecs[i].d1);
      check($sformatf("v%0d_m1_tnew", i),  m1_out_tnew,  vecs[i].t1);
      check($sformatf("v%0d_m1_bcnt", i),  m1_bcnt,      m1_bc);
      if (i == 0) check("m2_ready_after_rst", m2_in_ready, 1);
    end

    // Clear the elastic stage before the streaming test
    in_valid = 1'b0; stall = 1'b0; flush = 1'b1; out_ready = 1'b0;
    tick();
    flush = 1'b0;
    check("m2_clear_valid", m2_out_valid, 0);
    check("m2_clear_ready", m2_in_ready,  1);

    // MODE 2 streaming through the scoreboard
    idx = 1; cyc = 0; popped = 0;
    while ((idx <= 6 || q.size() > 0) && cyc < 40) begin
      in_valid  = (idx <= 6);
      in_data   = 32'(idx);
      in_tnew   = 2'd1;
      out_ready = (cyc < 6) ? or_pat[cyc] : 1'b1;
      #1;
      if (cyc < 6) check($sformatf("m2_in_ready_c%0d", cyc), m2_in_ready, rdy_pat[cyc]);
      if (m2_out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL m2_extra_output: got 0x%08h, expected no output", m2_out_data);
        end else begin
          exp_d = q.pop_front();
          check("m2_stream_data", m2_out_data, exp_d);
          popped++;
        end
      end
      if (in_valid && m2_in_ready) begin
        q.push_back(32'(idx));
        idx++;
      end
      tick();
      cyc++;
    end
    check("m2_stream_in_budget", cyc < 40, 1);
    check("m2_stream_count", popped, 6);
    in_valid = 1'b0;
    #1;
    check("m2_drained_valid", m2_out_valid, 0);

    // MODE 2: A in output, B in skid, then flush with C offered
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h0000000A;
    tick();
    in_data = 32'h0000000B;
    tick();
    check("m2_skid_ready_low", m2_in_ready, 0);
    check("m2_skid_out_a",     m2_out_data, 32'h0000000A);
    in_data = 32'h0000000C; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("m2_flush_valid", m2_out_valid, 0);
    check("m2_flush_ready", m2_in_ready,  1);
    check("m2_flush_data",  m2_out_data,  0);
    tick();
    check("m2_flush_no_c", m2_out_valid, 0);

    // CW=2 saturation, then reset
    rst_c2 = 1'b0; stall_c2 = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("c2_bcnt_%0d", k), c2_bcnt, (k < 3) ? k + 1 : 3);
      check($sformatf("c2_valid_%0d", k), c2_out_valid, 0);
    end
    stall_c2 = 1'b0; rst_c2 = 1'b1;
    tick();
    check("c2_rst_bcnt",  c2_bcnt,      0);
    check("c2_rst_valid", c2_out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
